// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single GPIO register port.
// Each access takes three cycles: IDLE (arbitrate and latch), ACCESS (strobe), RESP (read capture).
module gpio_bus_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              p_en,
   output logic              p_we,
   output logic [ADDR_W-1:0] p_addr,
   output logic [DATA_W-1:0] p_wdata,
   input  logic [DATA_W-1:0] p_rdata,
   output logic              busy
);

   // Handshake: a master holds req until it sees its one-cycle gnt pulse; read data
   // arrives later as a one-cycle rvalid pulse with rdata held until that master's next read.

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state;
   logic   owner;
   logic   last_gnt;
   logic   op_we;
   logic   sel;

   // With both masters requesting, the one not granted last wins.
   always_comb begin
      sel = 1'b0;
      if (m0_req && m1_req) sel = ~last_gnt;
      else if (m1_req)      sel = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         last_gnt  <= 1'b1;
         op_we     <= 1'b0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         p_en      <= 1'b0;
         p_we      <= 1'b0;
         p_addr    <= '0;
         p_wdata   <= '0;
      end else begin
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         p_en      <= 1'b0;
         p_we      <= 1'b0;
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  state    <= ACCESS;
                  owner    <= sel;
                  last_gnt <= sel;
                  op_we    <= sel ? m1_we : m0_we;
                  p_we     <= sel ? m1_we : m0_we;
                  p_addr   <= sel ? m1_addr : m0_addr;
                  p_wdata  <= sel ? m1_wdata : m0_wdata;
                  p_en     <= 1'b1;
                  m0_gnt   <= ~sel;
                  m1_gnt   <= sel;
               end
            end
            ACCESS: state <= RESP;
            RESP: begin
               state <= IDLE;
               // The peripheral's registered read data is valid during RESP.
               if (!op_we) begin
                  if (owner) begin
                     m1_rdata  <= p_rdata;
                     m1_rvalid <= 1'b1;
                  end else begin
                     m0_rdata  <= p_rdata;
                     m0_rvalid <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter: read, write, round-robin, reset abort, back-to-back.
// The peripheral model returns addr ^ 0x80 one cycle after a read strobe, 0 otherwise.
module tb_gpio_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       m0_req, m0_we, m1_req, m1_we;
   logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [7:0] m0_rdata, m1_rdata;
   logic       p_en, p_we, busy;
   logic [7:0] p_addr, p_wdata, p_rdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gpio_bus_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .p_en(p_en), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_rdata(p_rdata), .busy(busy)
   );

   always @(posedge clk) p_rdata <= (p_en && !p_we) ? (p_addr ^ 8'h80) : 8'h00;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_outs", {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, p_en, p_we, busy}, 7'd0);
      chk("reset_rdata", {m0_rdata, m1_rdata}, 16'h0000);
      chk("reset_paddr", {p_addr, p_wdata}, 16'h0000);
      tick();
      chk("idle_busy", busy, 1'b0);
   endtask

   task automatic test_read();
      m0_req = 1; m0_we = 0; m0_addr = 8'h25;
      tick();
      chk("rd_n1_pen", {p_en, p_we, m0_gnt, m1_gnt, busy}, 5'b10101);
      chk("rd_n1_paddr", p_addr, 8'h25);
      m0_req = 0;
      tick();
      chk("rd_n2_quiet", {p_en, m0_gnt, m0_rvalid, busy}, 4'b0001);
      tick();
      chk("rd_n3_rvalid", {m0_rvalid, m1_rvalid, busy}, 3'b100);
      chk("rd_n3_rdata", m0_rdata, 8'hA5);
      chk("rd_n3_m1", {m1_rdata, m1_gnt}, 9'd0);
      tick();
      chk("rd_n4_pulse", m0_rvalid, 1'b0);
      chk("rd_n4_hold", m0_rdata, 8'hA5);
   endtask

   task automatic test_write();
      m1_req = 1; m1_we = 1; m1_addr = 8'h2B; m1_wdata = 8'h3C;
      tick();
      chk("wr_n1_strobe", {p_en, p_we, m1_gnt, m0_gnt}, 4'b1110);
      chk("wr_n1_bus", {p_addr, p_wdata}, 16'h2B3C);
      m1_req = 0;
      tick();
      chk("wr_n2_off", {p_en, p_we, m1_gnt}, 3'b000);
      chk("wr_n2_hold", {p_addr, p_wdata}, 16'h2B3C);
      tick();
      chk("wr_n3_norv", {m0_rvalid, m1_rvalid}, 2'b00);
      chk("wr_n3_rdata", {m0_rdata, m1_rdata}, 16'hA500);
      tick();
      chk("wr_n4_norv", m1_rvalid, 1'b0);
   endtask

   task automatic test_round_robin();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m0_req = 1; m0_we = 0; m0_addr = 8'h10;
      m1_req = 1; m1_we = 0; m1_addr = 8'h20;
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk($sformatf("rr_gnt_c%0d", c), {m0_gnt, m1_gnt, p_en},
             {(c == 1 || c == 7), (c == 4 || c == 10), (c == 1 || c == 4 || c == 7 || c == 10)});
         chk($sformatf("rr_rv_c%0d", c), {m0_rvalid, m1_rvalid},
             {(c == 3 || c == 9), (c == 6 || c == 12)});
         if (c == 11) begin
            m0_req = 0; m1_req = 0;
         end
      end
      chk("rr_rdata", {m0_rdata, m1_rdata}, 16'h90A0);
      tick();
      chk("rr_idle", {busy, p_en}, 2'b00);
   endtask

   task automatic test_reset_abort();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m0_req = 1; m0_we = 0; m0_addr = 8'h25;
      tick();
      chk("ab_access", m0_gnt, 1'b1);
      m0_req = 0;
      tick();
      chk("ab_resp_busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("ab_after", {m0_rvalid, busy}, 2'b00);
      chk("ab_rdata", m0_rdata, 8'h00);
      tick();
      chk("ab_next", {m0_rvalid, busy, p_en}, 3'b000);
      chk("ab_rdata2", m0_rdata, 8'h00);
   endtask

   task automatic test_back_to_back();
      m0_req = 1; m0_we = 0; m0_addr = 8'h31;
      tick();
      chk("bb_n1_m0", {m0_gnt, m1_gnt}, 2'b10);
      m0_req = 0;
      m1_req = 1; m1_we = 0; m1_addr = 8'h42;
      tick();
      chk("bb_n2_ignore", {m1_gnt, p_en}, 2'b00);
      tick();
      chk("bb_n3_rv", {m0_rvalid, m1_gnt, p_en, busy}, 4'b1000);
      chk("bb_n3_rdata", m0_rdata, 8'hB1);
      tick();
      chk("bb_n4_m1", {m1_gnt, m0_gnt, p_en, m0_rvalid}, 4'b1010);
      chk("bb_n4_addr", p_addr, 8'h42);
      m1_req = 0;
      tick(); tick();
      chk("bb_n6_rv", {m1_rvalid, m0_rvalid}, 2'b10);
      chk("bb_n6_rdata", {m0_rdata, m1_rdata}, 16'hB1C2);
   endtask

   initial begin
      #1;
      test_reset();
      test_read();
      test_write();
      test_round_robin();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
